// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - data bus bundle between the M-stage access unit and memory
interface mem_access_unit_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - M-stage load/store to req/ack bus controller with load extension
// Optional misalignment trap enabled by defining MEM_ALIGN_CHK_EN.
module mem_access_unit #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [3:0]                mem_op,
  input  logic [31:0]               M_ALUAns,
  input  logic [31:0]               M_WD,
  output logic                      stall,
  output logic [31:0]               M_DMRD,
  output logic                      bus_err,
  output logic                      align_exc,
  mem_access_unit_if.master         bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [3:0] OP_LW  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LHU = 4'd3;
  localparam logic [3:0] OP_LB  = 4'd4;
  localparam logic [3:0] OP_LBU = 4'd5;
  localparam logic [3:0] OP_SW  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SB  = 4'd8;

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYC - 1);

  logic [1:0]  state;
  logic [3:0]  op_q;
  logic [1:0]  lane_q;
  logic [15:0] wait_cnt;
  logic        align_q;

  logic        op_valid;
  logic        is_store;
  logic        load_q;
  logic        trap;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [31:0] load_val;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign op_valid  = (mem_op >= OP_LW) && (mem_op <= OP_SB);
  assign is_store  = (mem_op >= OP_SW) && (mem_op <= OP_SB);
  assign load_q    = (op_q >= OP_LW) && (op_q <= OP_LBU);
  assign stall     = op_valid && (state != ST_DONE);
  assign align_exc = align_q;

`ifdef MEM_ALIGN_CHK_EN
  assign trap = (((mem_op == OP_LW) || (mem_op == OP_SW)) && (M_ALUAns[1:0] != 2'b00)) ||
                (((mem_op == OP_LH) || (mem_op == OP_LHU) || (mem_op == OP_SH)) && M_ALUAns[0]);
`else
  assign trap = 1'b0;
`endif

  // Lane enables and replicated store data; sub-size address bits are don't-care here.
  always_comb begin
    be_next    = 4'b1111;
    wdata_next = M_WD;
    case (mem_op)
      OP_LH, OP_LHU, OP_SH: begin
        be_next    = M_ALUAns[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{M_WD[15:0]}};
      end
      OP_LB, OP_LBU, OP_SB: begin
        be_next    = 4'b0001 << M_ALUAns[1:0];
        wdata_next = {4{M_WD[7:0]}};
      end
      default: begin
        be_next    = 4'b1111;
        wdata_next = M_WD;
      end
    endcase
  end

  always_comb begin
    byte_sel = 8'h00;
    case (lane_q)
      2'd0:    byte_sel = bus.bus_rdata[7:0];
      2'd1:    byte_sel = bus.bus_rdata[15:8];
      2'd2:    byte_sel = bus.bus_rdata[23:16];
      default: byte_sel = bus.bus_rdata[31:24];
    endcase
    half_sel = lane_q[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
    load_val = bus.bus_rdata;
    case (op_q)
      OP_LH:   load_val = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  load_val = {16'h0000, half_sel};
      OP_LB:   load_val = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  load_val = {24'h000000, byte_sel};
      default: load_val = bus.bus_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      op_q          <= 4'd0;
      lane_q        <= 2'd0;
      wait_cnt      <= 16'd0;
      align_q       <= 1'b0;
      bus_err       <= 1'b0;
      M_DMRD        <= 32'd0;
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= 32'd0;
      bus.bus_be    <= 4'd0;
      bus.bus_wdata <= 32'd0;
    end else begin
      bus_err <= 1'b0;
      align_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (op_valid) begin
            op_q   <= mem_op;
            lane_q <= M_ALUAns[1:0];
            if (trap) begin
              align_q <= 1'b1;
              state   <= ST_DONE;
            end else begin
              bus.bus_req   <= 1'b1;
              bus.bus_we    <= is_store;
              bus.bus_addr  <= {M_ALUAns[31:2], 2'b00};
              bus.bus_be    <= be_next;
              bus.bus_wdata <= wdata_next;
              wait_cnt      <= 16'd0;
              state         <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          // An ack in the final wait cycle still completes normally.
          if (bus.bus_ack) begin
            bus.bus_req <= 1'b0;
            if (load_q) M_DMRD <= load_val;
            state <= ST_DONE;
          end else if (wait_cnt == WAIT_LAST) begin
            bus.bus_req <= 1'b0;
            bus_err     <= 1'b1;
            if (load_q) M_DMRD <= 32'd0;
            state <= ST_DONE;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
module tb_mem_access_unit;
  localparam int T = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  mem_op;
  logic [31:0] M_ALUAns, M_WD, M_DMRD;
  logic        stall, bus_err, align_exc;

  mem_access_unit_if bus_if ();

  mem_access_unit #(.TIMEOUT_CYC(T)) dut (
    .clk(clk), .reset(reset), .mem_op(mem_op), .M_ALUAns(M_ALUAns), .M_WD(M_WD),
    .stall(stall), .M_DMRD(M_DMRD), .bus_err(bus_err), .align_exc(align_exc),
    .bus(bus_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr, wd, rdata;
    int          dly;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t        vecs[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] model_rd = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic [3:0] op, input logic [31:0] a, input logic [31:0] w,
                     input logic [31:0] r, input int d, input logic [31:0] e);
    vec_t v;
    v.op = op; v.addr = a; v.wd = w; v.rdata = r; v.dly = d; v.exp_rd = e;
    vecs.push_back(v);
  endtask

  function automatic int op_size(input logic [3:0] op);
    case (op)
      4'd1, 4'd6:       return 4;
      4'd2, 4'd3, 4'd7: return 2;
      4'd4, 4'd5, 4'd8: return 1;
      default:          return 0;
    endcase
  endfunction

  function automatic int lane_base(input logic [3:0] op, input logic [31:0] a);
    int s = op_size(op);
    return (int'(a[1:0]) / s) * s;
  endfunction

  function automatic logic [3:0] model_be(input logic [3:0] op, input logic [31:0] a);
    int s = op_size(op);
    return 4'(((1 << s) - 1) << lane_base(op, a));
  endfunction

  function automatic logic [31:0] model_wdata(input logic [3:0] op, input logic [31:0] wd);
    logic [31:0] w;
    int s = op_size(op);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = wd[8*(i % s) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] model_load(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] rd);
    logic [63:0] v, mask;
    int s = op_size(op);
    mask = (64'd1 << (8 * s)) - 64'd1;
    v = ({32'd0, rd} >> (8 * lane_base(op, a))) & mask;
    if ((op == 4'd2 || op == 4'd4) && v[8*s-1]) v = v | ~mask;
    return v[31:0];
  endfunction

  task automatic idle_cycle(input string tag);
    @(posedge clk); #1;
    mem_op = 4'd0;
    bus_if.bus_ack = 1'b1;
    bus_if.bus_rdata = $urandom;
    @(negedge clk);
    chk({tag, "_stall"}, 32'(stall), 32'd0);
    chk({tag, "_req"}, 32'(bus_if.bus_req), 32'd0);
    chk({tag, "_dmrd"}, M_DMRD, model_rd);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int   s, nreq;
    logic trap, err, ld, in_req;
    logic [31:0] exp_rd;
    string tag;
    tag = $sformatf("v%0d", idx);
    s = op_size(v.op);
    if (s == 0) begin
      @(posedge clk); #1;
      mem_op = v.op; M_ALUAns = v.addr; M_WD = v.wd; bus_if.bus_ack = 1'b0;
      @(negedge clk);
      chk({tag, "_stall_inv"}, 32'(stall), 32'd0);
      chk({tag, "_req_inv"}, 32'(bus_if.bus_req), 32'd0);
      return;
    end
    trap = 1'b0;
`ifdef MEM_ALIGN_CHK_EN
    trap = (int'(v.addr[1:0]) % s) != 0;
`endif
    ld   = (v.op >= 4'd1) && (v.op <= 4'd5);
    nreq = trap ? 0 : ((v.dly < T) ? v.dly + 1 : T);
    err  = !trap && (v.dly >= T);
    if (trap || !ld) exp_rd = model_rd;
    else if (err)    exp_rd = 32'd0;
    else             exp_rd = model_load(v.op, v.addr, v.rdata);
    for (int k = 0; k <= nreq + 1; k++) begin
      @(posedge clk); #1;
      mem_op = v.op; M_ALUAns = v.addr; M_WD = v.wd;
      bus_if.bus_ack = (k >= 1) && (k == v.dly + 1) && (k <= nreq);
      bus_if.bus_rdata = bus_if.bus_ack ? v.rdata : $urandom;
      @(negedge clk);
      in_req = (k >= 1) && (k <= nreq);
      chk({tag, "_stall"}, 32'(stall), 32'(k <= nreq));
      chk({tag, "_req"}, 32'(bus_if.bus_req), 32'(in_req));
      if (in_req) begin
        chk({tag, "_addr"}, bus_if.bus_addr, {v.addr[31:2], 2'b00});
        chk({tag, "_be"}, 32'(bus_if.bus_be), 32'(model_be(v.op, v.addr)));
        chk({tag, "_we"}, 32'(bus_if.bus_we), 32'(!ld));
        if (!ld) chk({tag, "_wdata"}, bus_if.bus_wdata, model_wdata(v.op, v.wd));
      end
      if (k == nreq + 1) begin
        chk({tag, "_dmrd_model"}, M_DMRD, exp_rd);
        chk({tag, "_dmrd_hand"}, M_DMRD, v.exp_rd);
        chk({tag, "_err"}, 32'(bus_err), 32'(err));
        chk({tag, "_align"}, 32'(align_exc), 32'(trap));
      end else begin
        chk({tag, "_err_q"}, 32'(bus_err), 32'd0);
        chk({tag, "_align_q"}, 32'(align_exc), 32'd0);
      end
    end
    model_rd = exp_rd;
    idle_cycle({tag, "_gap"});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; mem_op = 4'd0; M_ALUAns = 32'd0; M_WD = 32'd0;
    bus_if.bus_ack = 1'b0; bus_if.bus_rdata = 32'd0;

    add(4'd1, 32'h0000_1004, 32'h0,         32'hDEAD_BEEF, 0,   32'hDEAD_BEEF);
    add(4'd4, 32'h0000_2003, 32'h0,         32'h80FF_0000, 0,   32'hFFFF_FF80);
    add(4'd5, 32'h0000_2003, 32'h0,         32'h80FF_0000, 0,   32'h0000_0080);
    add(4'd2, 32'h0000_2002, 32'h0,         32'h80FF_0000, 0,   32'hFFFF_80FF);
    add(4'd8, 32'h0000_3001, 32'h1234_56AB, 32'h0,         3,   32'hFFFF_80FF);
    add(4'd1, 32'h0000_4000, 32'h0,         32'h1111_1111, 255, 32'h0000_0000);
    add(4'd3, 32'h0000_5000, 32'h0,         32'h1234_8765, 1,   32'h0000_8765);
    add(4'd7, 32'h0000_6002, 32'h0000_BEEF, 32'h0,         2,   32'h0000_8765);
    add(4'd6, 32'h0000_7002, 32'hCAFE_F00D, 32'h0,         0,   32'h0000_8765);
    add(4'd4, 32'h0000_8001, 32'h0,         32'h0000_7F00, 1,   32'h0000_007F);
    add(4'd12, 32'h0000_9000, 32'h0,        32'h0,         0,   32'h0000_007F);
    add(4'd2, 32'h0000_9000, 32'h0,         32'h0000_8001, 0,   32'hFFFF_8001);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_req", 32'(bus_if.bus_req), 32'd0);
    chk("rst_we", 32'(bus_if.bus_we), 32'd0);
    chk("rst_addr", bus_if.bus_addr, 32'd0);
    chk("rst_be", 32'(bus_if.bus_be), 32'd0);
    chk("rst_wdata", bus_if.bus_wdata, 32'd0);
    chk("rst_dmrd", M_DMRD, 32'd0);
    chk("rst_err", 32'(bus_err), 32'd0);
    chk("rst_align", 32'(align_exc), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) idle_cycle("idle");

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

    @(posedge clk); #1;
    mem_op = 4'd1; M_ALUAns = 32'h0000_A000; bus_if.bus_ack = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("mid_req_before_rst", 32'(bus_if.bus_req), 32'd1);
    #1;
    reset = 1'b1; mem_op = 4'd0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_req", 32'(bus_if.bus_req), 32'd0);
    chk("rst_mid_stall", 32'(stall), 32'd0);
    chk("rst_mid_dmrd", M_DMRD, 32'd0);
    model_rd = 32'd0;
    idle_cycle("post_rst");
    begin
      vec_t v;
      v.op = 4'd1; v.addr = 32'h0000_B008; v.wd = 32'h0; v.rdata = 32'h0BAD_F00D;
      v.dly = 0; v.exp_rd = 32'h0BAD_F00D;
      run_vec(v, 99);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
